// File: rtl/ft64_amo_pkg.sv
// Shared constants and types for the AMO shift/rotate read-modify-write sequencer.
package ft64_amo_pkg;

    localparam logic [5:0] AMO_OPCODE  = 6'h2F;

    localparam logic [5:0] FUNC_AMOSHL  = 6'h0C;
    localparam logic [5:0] FUNC_AMOSHR  = 6'h0D;
    localparam logic [5:0] FUNC_AMOASR  = 6'h0E;
    localparam logic [5:0] FUNC_AMOROL  = 6'h0F;
    localparam logic [5:0] FUNC_AMOSHLI = 6'h2C;
    localparam logic [5:0] FUNC_AMOSHRI = 6'h2D;
    localparam logic [5:0] FUNC_AMOASRI = 6'h2E;
    localparam logic [5:0] FUNC_AMOROLI = 6'h2F;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CALC = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } amoState_e;

    function automatic logic isLegalAmo(input logic [5:0] opcode, input logic [5:0] func);
        logic funcOk;
        case (func)
            FUNC_AMOSHL, FUNC_AMOSHR, FUNC_AMOASR, FUNC_AMOROL,
            FUNC_AMOSHLI, FUNC_AMOSHRI, FUNC_AMOASRI, FUNC_AMOROLI: funcOk = 1'b1;
            default:                                                 funcOk = 1'b0;
        endcase
        return (opcode == AMO_OPCODE) && funcOk;
    endfunction

endpackage

// File: rtl/FT64_shifth.sv
// Combinational shift/rotate unit for the AMO shift family; operation chosen by func.
module FT64_shifth
    import ft64_amo_pkg::*;
#(
    parameter int DMSB        = 31,
    parameter bit ROTATE_INSN = 1'b1,
    localparam int W          = DMSB + 1,
    localparam int SW         = $clog2(W)
) (
    input  logic [5:0]    func_i,
    input  logic [DMSB:0] a_i,
    input  logic [SW-1:0] b_i,
    output logic [DMSB:0] res_o,
    output logic          ov_o
);

    localparam logic [DMSB:0] NO_ROTATE = W'(32'hDEADDEAD);

    logic [DMSB:0] spill;
    logic [DMSB:0] rotated;

    // spill holds the bits pushed out of the top by a left shift; zero for b=0
    assign spill   = a_i >> (W - int'(b_i));
    assign rotated = (a_i << b_i) | spill;

    always_comb begin
        res_o = '0;
        ov_o  = 1'b0;
        case (func_i)
            FUNC_AMOSHL, FUNC_AMOSHLI: begin
                res_o = a_i << b_i;
                ov_o  = |spill;
            end
            FUNC_AMOSHR, FUNC_AMOSHRI: res_o = a_i >> b_i;
            FUNC_AMOASR, FUNC_AMOASRI: res_o = $signed(a_i) >>> b_i;
            FUNC_AMOROL, FUNC_AMOROLI: res_o = ROTATE_INSN ? rotated : NO_ROTATE;
            default:                   res_o = '0;
        endcase
    end

endmodule

// File: rtl/ft64_amo_shift_seq.sv
// AMO shift/rotate sequencer: locked bus read, shift via FT64_shifth, write back,
// and return the original memory word.
module ft64_amo_shift_seq
    import ft64_amo_pkg::*;
#(
    parameter bit ROTATE_INSN = 1'b1,
    parameter int AW          = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [31:0]   instr_i,
    input  logic [AW-1:0] adr_i,
    input  logic [31:0]   b_i,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [3:0]    sel_o,
    output logic [AW-1:0] adr_o,
    output logic [31:0]   dat_o,
    input  logic [31:0]   dat_i,
    input  logic          ack_i,
    input  logic          err_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_data_o,
    output logic          rsp_err_o
);

    amoState_e     state_q, state_d;
    logic [5:0]    func_q;
    logic [4:0]    shamt_q;
    logic [AW-1:0] adr_q;
    logic [31:0]   oldValue_q, oldValue_d;
    logic [31:0]   datOut_q;
    logic [31:0]   shiftRes;
    logic          errNext;
    logic          accept;
    logic          legalReq;

    logic          reqReady_q;
    logic          cyc_q, stb_q, we_q;
    logic [3:0]    sel_q;
    logic          rspValid_q, rspErr_q;
    logic [31:0]   rspData_q;

    logic          unusedOv;
    logic [46:0]   unusedBits;

    assign unusedBits = {instr_i[25:6], b_i[31:5]};

    assign accept   = req_valid_i && (state_q == IDLE);
    assign legalReq = isLegalAmo(instr_i[5:0], instr_i[31:26]);

    FT64_shifth #(
        .DMSB        (31),
        .ROTATE_INSN (ROTATE_INSN)
    ) u_shifth (
        .func_i (func_q),
        .a_i    (oldValue_q),
        .b_i    (shamt_q),
        .res_o  (shiftRes),
        .ov_o   (unusedOv)
    );

    always_comb begin
        state_d    = state_q;
        oldValue_d = oldValue_q;
        errNext    = rspErr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    oldValue_d = '0;
                    if (legalReq) begin
                        state_d = RD;
                        errNext = 1'b0;
                    end else begin
                        state_d = DONE;
                        errNext = 1'b1;
                    end
                end
            end
            // err wins over a simultaneous ack on both bus phases
            RD: begin
                if (err_i) begin
                    state_d = DONE;
                    errNext = 1'b1;
                end else if (ack_i) begin
                    state_d    = CALC;
                    oldValue_d = dat_i;
                end
            end
            CALC: state_d = WR;
            WR: begin
                if (err_i) begin
                    state_d = DONE;
                    errNext = 1'b1;
                end else if (ack_i) begin
                    state_d = DONE;
                    errNext = 1'b0;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    errNext = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            oldValue_q <= '0;
            func_q     <= '0;
            shamt_q    <= '0;
            adr_q      <= '0;
            datOut_q   <= '0;
        end else begin
            state_q    <= state_d;
            oldValue_q <= oldValue_d;
            if (accept) begin
                func_q  <= instr_i[31:26];
                shamt_q <= b_i[4:0];
                adr_q   <= adr_i;
            end
            if (state_q == CALC) begin
                datOut_q <= shiftRes;
            end
        end
    end

    // Outputs are registered from the next state so the bus sees clean edges only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reqReady_q <= 1'b1;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspData_q  <= '0;
        end else begin
            reqReady_q <= (state_d == IDLE);
            cyc_q      <= (state_d == RD) || (state_d == CALC) || (state_d == WR);
            stb_q      <= (state_d == RD) || (state_d == WR);
            we_q       <= (state_d == WR);
            sel_q      <= ((state_d == RD) || (state_d == WR)) ? 4'hF : 4'h0;
            rspValid_q <= (state_d == DONE);
            rspErr_q   <= (state_d == DONE) ? errNext : 1'b0;
            rspData_q  <= (state_d == DONE) ? oldValue_d : '0;
        end
    end

    assign req_ready_o = reqReady_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign sel_o       = sel_q;
    assign adr_o       = adr_q;
    assign dat_o       = datOut_q;
    assign rsp_valid_o = rspValid_q;
    assign rsp_err_o   = rspErr_q;
    assign rsp_data_o  = rspData_q;

endmodule

// File: tb/tb_ft64_amo_shift_seq.sv
// Directed testbench for ft64_amo_shift_seq with a cycle-accurate bus slave in the driver task.
module tb_ft64_amo_shift_seq;
    import ft64_amo_pkg::*;

    logic        clk, rstN;
    logic        reqValid, reqReady;
    logic [31:0] instr, adr, bOp;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adrOut, datOut, datIn;
    logic        ack, err;
    logic        rspValid, rspReady, rspErr;
    logic [31:0] rspData;

    logic        r0ReqReady, r0Cyc, r0Stb, r0We, r0RspValid, r0RspErr;
    logic [3:0]  r0Sel;
    logic [31:0] r0AdrOut, r0DatOut, r0RspData;

    int nVec, nFail;

    logic [31:0] obsWrData, obsR0WrData, obsRspData, obsR0RspData;
    logic        obsRspErr;
    int          obsRspCycle, obsStbLowCycles;
    bit          obsWrSeen, obsCycSeen, obsCycDrop, obsReadyBusy, obsRspUnstable, obsSelBad, obsTimeout;

    ft64_amo_shift_seq #(.ROTATE_INSN(1'b1), .AW(32)) dut (
        .clk_i(clk), .rst_ni(rstN), .req_valid_i(reqValid), .req_ready_o(reqReady),
        .instr_i(instr), .adr_i(adr), .b_i(bOp),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .sel_o(sel), .adr_o(adrOut), .dat_o(datOut),
        .dat_i(datIn), .ack_i(ack), .err_i(err),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_data_o(rspData), .rsp_err_o(rspErr)
    );

    ft64_amo_shift_seq #(.ROTATE_INSN(1'b0), .AW(32)) dutNoRot (
        .clk_i(clk), .rst_ni(rstN), .req_valid_i(reqValid), .req_ready_o(r0ReqReady),
        .instr_i(instr), .adr_i(adr), .b_i(bOp),
        .cyc_o(r0Cyc), .stb_o(r0Stb), .we_o(r0We), .sel_o(r0Sel), .adr_o(r0AdrOut), .dat_o(r0DatOut),
        .dat_i(datIn), .ack_i(ack), .err_i(err),
        .rsp_valid_o(r0RspValid), .rsp_ready_i(rspReady), .rsp_data_o(r0RspData), .rsp_err_o(r0RspErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one AMO and plays the bus slave; inputs change and outputs are sampled on negedges
    task automatic doAmo(input logic [5:0] func, input logic [31:0] memVal, input logic [4:0] shamt,
                         input int rdWait, input int wrWait, input bit rdErr, input int rspDelay);
        int cnt, rdCnt, wrCnt, holdCnt;
        bit done;
        obsWrData = 0; obsR0WrData = 0; obsRspData = 0; obsR0RspData = 0; obsRspErr = 0;
        obsRspCycle = -1; obsStbLowCycles = 0; obsWrSeen = 0; obsCycSeen = 0; obsCycDrop = 0;
        obsReadyBusy = 0; obsRspUnstable = 0; obsSelBad = 0; obsTimeout = 0;
        @(negedge clk);
        reqValid = 1'b1;
        instr    = {func, 20'h0, AMO_OPCODE};
        adr      = 32'h0000_1000;
        bOp      = {27'h7FF_FFFF, shamt};
        @(negedge clk);
        reqValid = 1'b0;
        cnt = 1; rdCnt = 0; wrCnt = 0; holdCnt = 0; done = 0;
        while (!done && cnt < 200) begin
            ack = 1'b0; err = 1'b0; datIn = 32'h0;
            if (reqReady) obsReadyBusy = 1;
            if (stb && sel !== 4'hF) obsSelBad = 1;
            if (rspValid) begin
                if (obsRspCycle < 0) begin
                    obsRspCycle  = cnt;
                    obsRspData   = rspData;
                    obsRspErr    = rspErr;
                    obsR0RspData = r0RspData;
                end else if (rspData !== obsRspData || rspErr !== obsRspErr) begin
                    obsRspUnstable = 1;
                end
                if (holdCnt >= rspDelay) begin
                    rspReady = 1'b1;
                    @(negedge clk);
                    rspReady = 1'b0;
                    done = 1;
                end else begin
                    holdCnt++;
                end
            end else begin
                if (cyc) obsCycSeen = 1;
                else if (obsCycSeen) obsCycDrop = 1;
                if (cyc && !stb) obsStbLowCycles++;
                if (stb && !we) begin
                    if (rdCnt == rdWait) begin
                        if (rdErr) err = 1'b1;
                        else begin ack = 1'b1; datIn = memVal; end
                    end else rdCnt++;
                end
                if (stb && we) begin
                    obsWrSeen = 1;
                    if (wrCnt == wrWait) begin
                        ack = 1'b1;
                        obsWrData   = datOut;
                        obsR0WrData = r0DatOut;
                    end else wrCnt++;
                end
            end
            if (!done) begin
                @(negedge clk);
                cnt++;
            end
        end
        ack = 1'b0; err = 1'b0;
        if (!done) obsTimeout = 1;
    endtask

    task automatic test_reset();
        nVec++;
        if ({cyc, stb, we, sel} !== 7'b0) begin
            nFail++; $display("[TB] FAIL reset_bus: got %b expected 0000000", {cyc, stb, we, sel});
        end
        nVec++;
        if ({rspValid, rspErr} !== 2'b0) begin
            nFail++; $display("[TB] FAIL reset_rsp: got %b expected 00", {rspValid, rspErr});
        end
        nVec++;
        if (reqReady !== 1'b1) begin
            nFail++; $display("[TB] FAIL reset_ready: got %b expected 1", reqReady);
        end
        nVec++;
        if ({adrOut, datOut, rspData} !== 96'h0) begin
            nFail++; $display("[TB] FAIL reset_data: got %h %h %h expected zeros", adrOut, datOut, rspData);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_shl();
        doAmo(FUNC_AMOSHL, 32'h0000_00F1, 5'd4, 0, 0, 1'b0, 0);
        nVec++;
        if (obsTimeout) begin nFail++; $display("[TB] FAIL shl_timeout: got timeout expected response"); end
        nVec++;
        if (obsWrData !== 32'h0000_0F10) begin
            nFail++; $display("[TB] FAIL shl_wdata: got %h expected 00000f10", obsWrData);
        end
        nVec++;
        if (obsRspData !== 32'h0000_00F1 || obsRspErr !== 1'b0) begin
            nFail++; $display("[TB] FAIL shl_rsp: got %h/%b expected 000000f1/0", obsRspData, obsRspErr);
        end
        nVec++;
        if (obsRspCycle != 4) begin
            nFail++; $display("[TB] FAIL shl_latency: got %0d expected 4", obsRspCycle);
        end
        nVec++;
        if (obsStbLowCycles != 1 || obsSelBad) begin
            nFail++; $display("[TB] FAIL shl_stb: got %0d low cycles sel_bad=%0d expected 1/0", obsStbLowCycles, obsSelBad);
        end
        nVec++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
            nFail++; $display("[TB] FAIL shl_idle: got ready=%b valid=%b expected 1/0", reqReady, rspValid);
        end
    endtask

    task automatic test_asr_shr();
        doAmo(FUNC_AMOASRI, 32'h8000_0000, 5'd31, 0, 0, 1'b0, 0);
        nVec++;
        if (obsWrData !== 32'hFFFF_FFFF) begin
            nFail++; $display("[TB] FAIL asri_wdata: got %h expected ffffffff", obsWrData);
        end
        nVec++;
        if (obsRspData !== 32'h8000_0000) begin
            nFail++; $display("[TB] FAIL asri_rsp: got %h expected 80000000", obsRspData);
        end
        doAmo(FUNC_AMOSHR, 32'h8000_0000, 5'd31, 0, 0, 1'b0, 0);
        nVec++;
        if (obsWrData !== 32'h0000_0001) begin
            nFail++; $display("[TB] FAIL shr_wdata: got %h expected 00000001", obsWrData);
        end
    endtask

    task automatic test_rol();
        doAmo(FUNC_AMOROL, 32'h8000_0001, 5'd1, 0, 0, 1'b0, 0);
        nVec++;
        if (obsWrData !== 32'h0000_0003) begin
            nFail++; $display("[TB] FAIL rol_wdata: got %h expected 00000003", obsWrData);
        end
        nVec++;
        if (obsR0WrData !== 32'hDEAD_DEAD) begin
            nFail++; $display("[TB] FAIL rol_norotate_wdata: got %h expected deaddead", obsR0WrData);
        end
        nVec++;
        if (obsR0RspData !== 32'h8000_0001) begin
            nFail++; $display("[TB] FAIL rol_norotate_rsp: got %h expected 80000001", obsR0RspData);
        end
    endtask

    task automatic test_read_err();
        doAmo(FUNC_AMOSHLI, 32'h1234_5678, 5'd3, 1, 0, 1'b1, 0);
        nVec++;
        if (obsWrSeen) begin nFail++; $display("[TB] FAIL rderr_nowrite: got write strobe expected none"); end
        nVec++;
        if (obsRspErr !== 1'b1 || obsRspData !== 32'h0) begin
            nFail++; $display("[TB] FAIL rderr_rsp: got %h/%b expected 00000000/1", obsRspData, obsRspErr);
        end
        nVec++;
        if (obsRspCycle != 3) begin
            nFail++; $display("[TB] FAIL rderr_latency: got %0d expected 3", obsRspCycle);
        end
    endtask

    task automatic test_illegal();
        doAmo(6'h01, 32'hAAAA_5555, 5'd2, 0, 0, 1'b0, 0);
        nVec++;
        if (obsCycSeen) begin nFail++; $display("[TB] FAIL illegal_nocyc: got cyc_o high expected never"); end
        nVec++;
        if (obsRspCycle != 1) begin
            nFail++; $display("[TB] FAIL illegal_latency: got %0d expected 1", obsRspCycle);
        end
        nVec++;
        if (obsRspErr !== 1'b1 || obsRspData !== 32'h0) begin
            nFail++; $display("[TB] FAIL illegal_rsp: got %h/%b expected 00000000/1", obsRspData, obsRspErr);
        end
    endtask

    task automatic test_wait_stall();
        doAmo(FUNC_AMOSHLI, 32'h1234_5678, 5'd8, 3, 3, 1'b0, 5);
        nVec++;
        if (obsTimeout) begin nFail++; $display("[TB] FAIL stall_timeout: got timeout expected response"); end
        nVec++;
        if (obsWrData !== 32'h3456_7800) begin
            nFail++; $display("[TB] FAIL stall_wdata: got %h expected 34567800", obsWrData);
        end
        nVec++;
        if (obsCycDrop || obsStbLowCycles != 1) begin
            nFail++; $display("[TB] FAIL stall_cyc: got drop=%0d stb_low=%0d expected 0/1", obsCycDrop, obsStbLowCycles);
        end
        nVec++;
        if (obsRspCycle != 10) begin
            nFail++; $display("[TB] FAIL stall_latency: got %0d expected 10", obsRspCycle);
        end
        nVec++;
        if (obsRspUnstable || obsReadyBusy) begin
            nFail++; $display("[TB] FAIL stall_hold: got unstable=%0d ready_busy=%0d expected 0/0", obsRspUnstable, obsReadyBusy);
        end
        nVec++;
        if (obsRspData !== 32'h1234_5678) begin
            nFail++; $display("[TB] FAIL stall_rsp: got %h expected 12345678", obsRspData);
        end
    endtask

    task automatic test_back_to_back();
        doAmo(FUNC_AMOSHRI, 32'hF000_0000, 5'd4, 0, 0, 1'b0, 0);
        nVec++;
        if (obsWrData !== 32'h0F00_0000) begin
            nFail++; $display("[TB] FAIL b2b_shri_wdata: got %h expected 0f000000", obsWrData);
        end
        doAmo(FUNC_AMOASR, 32'hF000_0000, 5'd4, 0, 0, 1'b0, 0);
        nVec++;
        if (obsWrData !== 32'hFF00_0000) begin
            nFail++; $display("[TB] FAIL b2b_asr_wdata: got %h expected ff000000", obsWrData);
        end
        nVec++;
        if (adrOut !== 32'h0000_1000) begin
            nFail++; $display("[TB] FAIL b2b_adr: got %h expected 00001000", adrOut);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        bit inWr;
        @(negedge clk);
        reqValid = 1'b1;
        instr    = {FUNC_AMOROLI, 20'h0, AMO_OPCODE};
        bOp      = 32'd5;
        @(negedge clk);
        reqValid = 1'b0;
        cnt = 0; inWr = 0;
        while (!inWr && cnt < 20) begin
            ack = 1'b0; datIn = 32'h0;
            if (stb && we) inWr = 1;
            else begin
                if (stb) begin ack = 1'b1; datIn = 32'h0000_0042; end
                @(negedge clk);
                cnt++;
            end
        end
        ack = 1'b0;
        nVec++;
        if (!inWr) begin nFail++; $display("[TB] FAIL rstmid_reach_wr: got no write phase expected WR"); end
        #2 rstN = 1'b0;
        #1;
        nVec++;
        if ({cyc, stb, we} !== 3'b000) begin
            nFail++; $display("[TB] FAIL rstmid_async_drop: got %b expected 000", {cyc, stb, we});
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nVec++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0 || cyc !== 1'b0) begin
            nFail++; $display("[TB] FAIL rstmid_idle: got ready=%b valid=%b cyc=%b expected 1/0/0", reqReady, rspValid, cyc);
        end
    endtask

    initial begin
        nVec = 0; nFail = 0;
        rstN = 1'b0; reqValid = 1'b0; instr = 32'h0; adr = 32'h0; bOp = 32'h0;
        datIn = 32'h0; ack = 1'b0; err = 1'b0; rspReady = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_shl();
        test_asr_shr();
        test_rol();
        test_read_err();
        test_illegal();
        test_wait_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
